// File: rtl/mult_ctrl.sv
// Sequencing FSM for the 32x32 shift-add multiplier datapath: one load cycle, N_ITER add/shift cycles, one done cycle.
// Optional abort input is compiled in when MULT_CTRL_ABORT_EN is defined.
module mult_ctrl #(
    parameter int unsigned N_ITER = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic start_i,
`ifdef MULT_CTRL_ABORT_EN
    input  logic abort_i,
`endif
    input  logic b_lsb_i,
    output logic a_sel_o,
    output logic b_sel_o,
    output logic prod_sel_o,
    output logic add_sel_c_o,
    output logic busy_o,
    output logic done_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CALC = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

    // Counter must hold N_ITER-1 without wrapping.
    if ((N_ITER == 0) || (64'(N_ITER) >= (64'(1) << CNT_W))) begin : g_cfg_check
        $error("mult_ctrl: CNT_W too small for N_ITER");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_sel_q, a_sel_d;
    logic             b_sel_q, b_sel_d;
    logic             prod_sel_q, prod_sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             abort_w;

`ifdef MULT_CTRL_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    // State, counter and registered select lines.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            a_sel_q    <= 1'b0;
            b_sel_q    <= 1'b0;
            prod_sel_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_sel_q    <= a_sel_d;
            b_sel_q    <= b_sel_d;
            prod_sel_q <= prod_sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next state, and outputs decoded from the next state so they register alongside it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_sel_d    = 1'b0;
        b_sel_d    = 1'b0;
        prod_sel_d = 1'b1;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = abort_w ? ST_IDLE : ST_CALC;
            end
            ST_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (abort_w) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_LOAD: begin
                prod_sel_d = 1'b0;
                busy_d     = 1'b1;
            end
            ST_CALC: begin
                a_sel_d = 1'b1;
                b_sel_d = 1'b1;
                busy_d  = 1'b1;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign a_sel_o    = a_sel_q;
    assign b_sel_o    = b_sel_q;
    assign prod_sel_o = prod_sel_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

    // Mealy add steering: accumulate A only when the current multiplier bit is set.
    assign add_sel_c_o = (state_q == ST_CALC) ? ~b_lsb_i : 1'b1;

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: vector table, timing sequences and randomized run against an operation-phase model.
module tb_mult_ctrl;

    localparam int N = 32;
`ifdef MULT_CTRL_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, b_lsb;
`ifdef MULT_CTRL_ABORT_EN
    logic abort;
`endif
    logic a_sel, b_sel, prod_sel, add_sel, busy, done;

    mult_ctrl #(.N_ITER(N), .CNT_W(6)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
`ifdef MULT_CTRL_ABORT_EN
        .abort_i     (abort),
`endif
        .b_lsb_i     (b_lsb),
        .a_sel_o     (a_sel),
        .b_sel_o     (b_sel),
        .prod_sel_o  (prod_sel),
        .add_sel_c_o (add_sel),
        .busy_o      (busy),
        .done_o      (done)
    );

    int nvec = 0;
    int nmis = 0;
    // Position within an operation: -1 idle, 0 load, 1..N calc, N+1 done.
    int phase = -1;

    typedef struct {
        logic       rst;
        logic       st;
        logic       bl;
        logic [5:0] exp;
        logic [5:0] mask;
    } vec_t;

    localparam logic [5:0] V_IDLE   = 6'b001100;
    localparam logic [5:0] M_ALL    = 6'b111111;
    localparam logic [5:0] M_NO_ADD = 6'b111011;

    function automatic logic [5:0] outs();
        return {a_sel, b_sel, prod_sel, add_sel, busy, done};
    endfunction

    function automatic logic [5:0] model_out(input int ph, input logic bl);
        bit ld, cl, dn;
        ld = (ph == 0);
        cl = (ph >= 1) && (ph <= N);
        dn = (ph == N + 1);
        return {cl, cl, ~ld, (cl ? ~bl : 1'b1), (ld | cl), dn};
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp,
                         input logic [5:0] mask);
        nvec++;
        if (((got ^ exp) & mask) !== 6'b0) begin
            nmis++;
            $display("FAIL %s @%0t: got {a,b,prod,add,busy,done}=%b, expected %b (mask %b)",
                     name, $time, got, exp, mask);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare at the falling edge.
    task automatic step(input logic rst, input logic st, input logic bl, input logic ab);
        reset = rst;
        start = st;
        b_lsb = bl;
`ifdef MULT_CTRL_ABORT_EN
        abort = ab;
`endif
        @(posedge clk);
        if (rst)                               phase = -1;
        else if (phase < 0)                    phase = st ? 0 : -1;
        else if (ab && ABORT_EN && phase <= N) phase = -1;
        else if (phase == N + 1)               phase = -1;
        else                                   phase = phase + 1;
        @(negedge clk);
        check("model", outs(), model_out(phase, bl), (phase == 0) ? M_NO_ADD : M_ALL);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom), 1'b0);
    endtask

    // Runs an operation from IDLE; returns busy count and the offset of the done pulse.
    task automatic run_op(input int ign_off, output int busy_cnt, output int done_at,
                          output int extra_loads);
        busy_cnt = 0; done_at = -1; extra_loads = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        if (busy) busy_cnt++;
        for (int k = 2; k <= N + 8; k++) begin
            step(1'b0, (k == ign_off) || (k == N + 3), 1'($urandom), 1'b0);
            if (busy) busy_cnt++;
            if (done && done_at < 0) done_at = k;
            if (!prod_sel) extra_loads++;
        end
    endtask

    vec_t tbl[7];
    int bc, da, xl, nd;
    int loads[$];
    int dones[$];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, V_IDLE,    M_ALL};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 6'b000010, M_NO_ADD};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 6'b111010, M_ALL};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 6'b111110, M_ALL};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 6'b111010, M_ALL};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 6'b111010, M_ALL};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 6'b111110, M_ALL};

        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].rst, tbl[i].st, tbl[i].bl, 1'b0);
            check($sformatf("table[%0d]", i), outs(), tbl[i].exp, tbl[i].mask);
        end
        idle_cycles(N + 4);

        // Single operation; start pulses at CALC cycle 5 and in DONE must be ignored.
        run_op(8, bc, da, xl);
        check_int("busy_cycles", bc, N + 1);
        check_int("done_offset", da, N + 2);
        check_int("extra_loads", xl, 0);
        idle_cycles(3);

        // Reset held two cycles from CALC cnt=10.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 2; k <= 12; k++) step(1'b0, 1'b0, 1'($urandom), 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("reset_mid_calc", outs(), V_IDLE, M_ALL);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("reset_priority", outs(), V_IDLE, M_ALL);
        nd = 0;
        for (int k = 0; k < N + 6; k++) begin
            step(1'b0, 1'b0, 1'($urandom), 1'b0);
            if (done) nd++;
        end
        check_int("no_done_after_reset", nd, 0);

        // Back-to-back with start held high.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 100; c++) begin
            step(1'b0, 1'b1, 1'($urandom), 1'b0);
            if (!prod_sel) loads.push_back(c);
            if (done) dones.push_back(c);
        end
        check_int("b2b_load_count", loads.size(), 3);
        check_int("b2b_done_count", dones.size(), 2);
        if (loads.size() == 3) begin
            check_int("b2b_load0", loads[0], 1);
            check_int("b2b_load1", loads[1], 36);
            check_int("b2b_load2", loads[2], 71);
        end
        if (dones.size() == 2) begin
            check_int("b2b_done0", dones[0], 34);
            check_int("b2b_done1", dones[1], 69);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);

`ifdef MULT_CTRL_ABORT_EN
        // Abort at CALC cycle 7, then a full operation.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 2; k <= 9; k++) step(1'b0, 1'b0, 1'($urandom), 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("abort_to_idle", outs(), V_IDLE, M_ALL);
        nd = 0;
        for (int k = 0; k < N + 6; k++) begin
            step(1'b0, 1'b0, 1'($urandom), 1'b0);
            if (done) nd++;
        end
        check_int("no_done_after_abort", nd, 0);
        run_op(0, bc, da, xl);
        check_int("post_abort_busy", bc, N + 1);
        check_int("post_abort_done", da, N + 2);
        idle_cycles(3);
`endif

        // Randomized traffic against the phase model.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom), 1'(ABORT_EN && ($urandom_range(0, 49) == 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
